lcd_timing_sequencer: RTL and testbench

//  Dot/line timing master for the whizgraphics renderer. Walks each frame through the
//  OAM-search / transfer / hblank / vblank modes and issues one drawline strobe per

---
 rtl/lcd_timing_sequencer_pkg.sv | 45 ++++
 rtl/lcd_timing_sequencer_stat.sv | 51 +++++
 rtl/lcd_timing_sequencer.sv | 135 +++++++++++++
 tb/tb_lcd_timing_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_sequencer_pkg.sv
// video_types: shared types and default timing for the LCD timing sequencer.
//   LcdMode        - STAT mode encoding (00 hblank, 01 vblank, 10 oam, 11 xfer)
//   StatIrqEnable  - STAT interrupt enable bits {lyc, oam, vblank, hblank}
//   LCD_*          - default frame timing
//   lcd_mode_decode - mode from the current (ly, dot) pair
package video_types;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'b00,
    MODE_VBLANK = 2'b01,
    MODE_OAM    = 2'b10,
    MODE_XFER   = 2'b11
  } LcdMode;

  typedef struct packed {
    logic lyc;
    logic oam;
    logic vblank;
    logic hblank;
  } StatIrqEnable;

  localparam int LCD_DOTS_PER_LINE = 456;
  localparam int LCD_OAM_DOTS      = 80;
  localparam int LCD_XFER_DOTS     = 172;
  localparam int LCD_VISIBLE_LINES = 144;
  localparam int LCD_TOTAL_LINES   = 154;

  // vblank lines win over the dot position; within a visible line the dot
  // position alone selects oam -> xfer -> hblank.
  function automatic LcdMode lcd_mode_decode(
    input logic [7:0] ly,
    input logic [8:0] dot,
    input logic [7:0] vis_lines,
    input logic [8:0] oam_end,
    input logic [8:0] xfer_end
  );
    LcdMode m;
    if (ly >= vis_lines)     m = MODE_VBLANK;
    else if (dot < oam_end)  m = MODE_OAM;
    else if (dot < xfer_end) m = MODE_XFER;
    else                     m = MODE_HBLANK;
    return m;
  endfunction

endpackage

// File: rtl/lcd_timing_sequencer_stat.sv
// lcd_stat_irq_gen: STAT interrupt edge detector.
//   clk, reset_n   - clock, async active-low reset
//   lcd_enable_i   - LCD enable level; low clears the edge history
//   start_i        - first enabled clock after the LCD was off
//   mode_i         - mode the sequencer is about to register
//   lyc_match_i    - lyc_match the sequencer is about to register
//   stat_ie_i      - STAT interrupt enables
//   stat_irq_o     - one-clock pulse on a 0->1 of the combined STAT source
// Inputs are the sequencer's next-state values so the registered pulse lines
// up with the registered mode/ly it describes.
module lcd_stat_irq_gen
  import video_types::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         lcd_enable_i,
  input  logic         start_i,
  input  LcdMode       mode_i,
  input  logic         lyc_match_i,
  input  StatIrqEnable stat_ie_i,
  output logic         stat_irq_o
);

  logic src_d, src_q;
  logic irq_d, irq_q;

  always_comb begin
    src_d = lcd_enable_i &
            ((stat_ie_i.lyc    & lyc_match_i) |
             (stat_ie_i.oam    & (mode_i == MODE_OAM)) |
             (stat_ie_i.vblank & (mode_i == MODE_VBLANK)) |
             (stat_ie_i.hblank & (mode_i == MODE_HBLANK)));
    // On the power-up clock only an lyc==0 match may interrupt; the oam
    // source is still recorded so it cannot fire a clock later.
    if (start_i) irq_d = lcd_enable_i & stat_ie_i.lyc & lyc_match_i;
    else         irq_d = src_d & ~src_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      src_q <= src_d;
      irq_q <= irq_d;
    end
  end

  assign stat_irq_o = irq_q;

endmodule

// File: rtl/lcd_timing_sequencer.sv
// lcd_timing_sequencer: dot/line timing master for the renderer.
//   clk, reset_n  - clock, async active-low reset
//   lcd_enable    - LCD enable level; low holds every output at 0
//   lyc, stat_ie  - LY compare value, STAT interrupt enables
//   ly, dot, mode - current line, dot, STAT mode
//   lyc_match     - ly == lyc
//   drawline, frame_done, vblank_irq, stat_irq - one-clock strobes
//   oam_lock, vram_lock - CPU access refusal flags
// Every output is registered from the next-state dot/ly so it describes the
// same dot/ly pair that the counters show on that clock.
module lcd_timing_sequencer
  import video_types::*;
#(
  parameter int DOTS_PER_LINE = LCD_DOTS_PER_LINE,
  parameter int OAM_DOTS      = LCD_OAM_DOTS,
  parameter int XFER_DOTS     = LCD_XFER_DOTS,
  parameter int VISIBLE_LINES = LCD_VISIBLE_LINES,
  parameter int TOTAL_LINES   = LCD_TOTAL_LINES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  output logic [7:0] ly,
  output logic [8:0] dot,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       drawline,
  output logic       frame_done,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       oam_lock,
  output logic       vram_lock
);

  if ((OAM_DOTS + XFER_DOTS >= DOTS_PER_LINE) || (DOTS_PER_LINE > 512) ||
      (TOTAL_LINES > 256) || (VISIBLE_LINES >= TOTAL_LINES)) begin : g_param_check
    $error("lcd_timing_sequencer: illegal timing parameters");
  end

  localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] OAM_END  = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_END = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LY_VIS   = 8'(VISIBLE_LINES);
  localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);

  logic         active_q;
  logic         start;
  logic [8:0]   dot_d, dot_q;
  logic [7:0]   ly_d, ly_q;
  LcdMode       mode_d, mode_q;
  logic         lyc_match_d, lyc_match_q;
  logic         drawline_d, drawline_q;
  logic         frame_done_d, frame_done_q;
  logic         vblank_d, vblank_q;
  logic         oam_lock_d, oam_lock_q;
  logic         vram_lock_d, vram_lock_q;
  StatIrqEnable ie;

  assign ie = StatIrqEnable'(stat_ie);

  always_comb begin
    start = lcd_enable & ~active_q;
    dot_d = 9'd0;
    ly_d  = 8'd0;
    // The power-up clock keeps dot/ly at 0 so the frame starts at line 0, dot 0.
    if (lcd_enable && active_q) begin
      if (dot_q == DOT_LAST) begin
        dot_d = 9'd0;
        ly_d  = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + 9'd1;
        ly_d  = ly_q;
      end
    end

    mode_d       = lcd_enable ? lcd_mode_decode(ly_d, dot_d, LY_VIS, OAM_END, XFER_END)
                              : MODE_HBLANK;
    lyc_match_d  = lcd_enable & (ly_d == lyc);
    drawline_d   = lcd_enable & (ly_d < LY_VIS) & (dot_d == OAM_END);
    vblank_d     = lcd_enable & (ly_d == LY_VIS) & (dot_d == 9'd0);
    frame_done_d = lcd_enable & (ly_d == LY_LAST) & (dot_d == DOT_LAST);
    oam_lock_d   = lcd_enable & ((mode_d == MODE_OAM) | (mode_d == MODE_XFER));
    vram_lock_d  = lcd_enable & (mode_d == MODE_XFER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q     <= 1'b0;
      dot_q        <= 9'd0;
      ly_q         <= 8'd0;
      mode_q       <= MODE_HBLANK;
      lyc_match_q  <= 1'b0;
      drawline_q   <= 1'b0;
      frame_done_q <= 1'b0;
      vblank_q     <= 1'b0;
      oam_lock_q   <= 1'b0;
      vram_lock_q  <= 1'b0;
    end else begin
      active_q     <= lcd_enable;
      dot_q        <= dot_d;
      ly_q         <= ly_d;
      mode_q       <= mode_d;
      lyc_match_q  <= lyc_match_d;
      drawline_q   <= drawline_d;
      frame_done_q <= frame_done_d;
      vblank_q     <= vblank_d;
      oam_lock_q   <= oam_lock_d;
      vram_lock_q  <= vram_lock_d;
    end
  end

  lcd_stat_irq_gen u_stat (
    .clk          (clk),
    .reset_n      (reset_n),
    .lcd_enable_i (lcd_enable),
    .start_i      (start),
    .mode_i       (mode_d),
    .lyc_match_i  (lyc_match_d),
    .stat_ie_i    (ie),
    .stat_irq_o   (stat_irq)
  );

  assign ly         = ly_q;
  assign dot        = dot_q;
  assign mode       = mode_q;
  assign lyc_match  = lyc_match_q;
  assign drawline   = drawline_q;
  assign frame_done = frame_done_q;
  assign vblank_irq = vblank_q;
  assign oam_lock   = oam_lock_q;
  assign vram_lock  = vram_lock_q;

endmodule

// File: tb/tb_lcd_timing_sequencer.sv
module tb_lcd_timing_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, rst_c;
  logic en_a, en_b, en_c;
  logic [7:0] lyc_a, lyc_b, lyc_c;
  logic [3:0] ie_a, ie_b, ie_c;

  logic [7:0] ly_a, ly_b, ly_c;
  logic [8:0] dot_a, dot_b, dot_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic lm_a, dl_a, fd_a, vb_a, st_a, ol_a, vl_a;
  logic lm_b, dl_b, fd_b, vb_b, st_b, ol_b, vl_b;
  logic lm_c, dl_c, fd_c, vb_c, st_c, ol_c, vl_c;

  lcd_timing_sequencer u_a (
    .clk(clk), .reset_n(reset_n), .lcd_enable(en_a), .lyc(lyc_a), .stat_ie(ie_a),
    .ly(ly_a), .dot(dot_a), .mode(mode_a), .lyc_match(lm_a), .drawline(dl_a),
    .frame_done(fd_a), .vblank_irq(vb_a), .stat_irq(st_a), .oam_lock(ol_a), .vram_lock(vl_a));

  lcd_timing_sequencer u_b (
    .clk(clk), .reset_n(reset_n), .lcd_enable(en_b), .lyc(lyc_b), .stat_ie(ie_b),
    .ly(ly_b), .dot(dot_b), .mode(mode_b), .lyc_match(lm_b), .drawline(dl_b),
    .frame_done(fd_b), .vblank_irq(vb_b), .stat_irq(st_b), .oam_lock(ol_b), .vram_lock(vl_b));

  lcd_timing_sequencer #(
    .DOTS_PER_LINE(16), .OAM_DOTS(4), .XFER_DOTS(6), .VISIBLE_LINES(3), .TOTAL_LINES(5)
  ) u_c (
    .clk(clk), .reset_n(rst_c), .lcd_enable(en_c), .lyc(lyc_c), .stat_ie(ie_c),
    .ly(ly_c), .dot(dot_c), .mode(mode_c), .lyc_match(lm_c), .drawline(dl_c),
    .frame_done(fd_c), .vblank_irq(vb_c), .stat_irq(st_c), .oam_lock(ol_c), .vram_lock(vl_c));

  wire [25:0] all_a = {ly_a, dot_a, mode_a, lm_a, dl_a, fd_a, vb_a, st_a, ol_a, vl_a};
  wire [25:0] all_b = {ly_b, dot_b, mode_b, lm_b, dl_b, fd_b, vb_b, st_b, ol_b, vl_b};
  wire [25:0] all_c = {ly_c, dot_c, mode_c, lm_c, dl_c, fd_c, vb_c, st_c, ol_c, vl_c};

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int exp_mode(int l, int d, int vis, int oam, int xe);
    if (l >= vis)     return 1;
    else if (d < oam) return 2;
    else if (d < xe)  return 3;
    else              return 0;
  endfunction

  localparam int FRAME  = 456 * 154;
  localparam int B_OFF  = 70 * 456 + 100;
  localparam int B_BACK = B_OFF + 2;

  initial begin
    int e_dot, e_ly, e_mode, n_draw, n_match, bd, lyc_cur;

    reset_n = 1'b0; rst_c = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b0;
    lyc_a = 8'd5; ie_a = 4'b1000;
    lyc_b = 8'd0; ie_b = 4'b0000;
    lyc_c = 8'd0; ie_c = 4'b0000;
    n_draw = 0; n_match = 0;

    repeat (3) step();
    chk("reset_a_all_zero", 32'(all_a), 0);
    chk("reset_b_all_zero", 32'(all_b), 0);
    chk("reset_c_all_zero", 32'(all_c), 0);

    reset_n = 1'b1;

    for (int cyc = 0; cyc <= FRAME; cyc++) begin
      step();
      e_dot  = cyc % 456;
      e_ly   = (cyc / 456) % 154;
      e_mode = exp_mode(e_ly, e_dot, 144, 80, 252);
      chk("a_dot", 32'(dot_a), e_dot);
      chk("a_ly", 32'(ly_a), e_ly);
      chk("a_mode", 32'(mode_a), e_mode);
      chk("a_oam_lock", 32'(ol_a), (e_mode >= 2) ? 1 : 0);
      chk("a_vram_lock", 32'(vl_a), (e_mode == 3) ? 1 : 0);
      chk("a_drawline", 32'(dl_a), (e_ly < 144 && e_dot == 80) ? 1 : 0);
      chk("a_vblank_irq", 32'(vb_a), (e_ly == 144 && e_dot == 0) ? 1 : 0);
      chk("a_frame_done", 32'(fd_a), (e_ly == 153 && e_dot == 455) ? 1 : 0);
      chk("a_lyc_match", 32'(lm_a), (e_ly == 5) ? 1 : 0);
      chk("a_stat_irq", 32'(st_a), (e_ly == 5 && e_dot == 0) ? 1 : 0);
      if (cyc < FRAME) begin
        n_draw  += dl_a ? 1 : 0;
        n_match += lm_a ? 1 : 0;
      end
      if (cyc == 5 * 456 + 10) ie_a = 4'b1001;
      if (cyc == 6 * 456)      ie_a = 4'b1000;

      if (cyc <= B_OFF) begin
        chk("b_dot", 32'(dot_b), e_dot);
        chk("b_ly", 32'(ly_b), e_ly);
        if (cyc == B_OFF) en_b = 1'b0;
      end else if (cyc == B_OFF + 1) begin
        chk("b_disable_all_zero", 32'(all_b), 0);
        en_b = 1'b1;
      end else if (cyc <= B_BACK + 80) begin
        bd = cyc - B_BACK;
        chk("b_restart_dot", 32'(dot_b), bd);
        chk("b_restart_ly", 32'(ly_b), 0);
        chk("b_restart_mode", 32'(mode_b), exp_mode(0, bd, 144, 80, 252));
        chk("b_restart_drawline", 32'(dl_b), (bd == 80) ? 1 : 0);
        chk("b_restart_vblank", 32'(vb_b), 0);
      end
    end
    chk("a_drawlines_per_frame", 32'(n_draw), 144);
    chk("a_lyc_match_clocks", 32'(n_match), 456);

    // Small-parameter instance: lyc==0 interrupt on the power-up clock.
    en_c = 1'b1; lyc_c = 8'd0; ie_c = 4'b1000;
    rst_c = 1'b1;
    step();
    chk("c_start_dot", 32'(dot_c), 0);
    chk("c_start_ly", 32'(ly_c), 0);
    chk("c_start_mode", 32'(mode_c), 2);
    chk("c_start_lyc_irq", 32'(st_c), 1);
    ie_c = 4'b0100; lyc_c = 8'd2; lyc_cur = 2;

    for (int cyc = 1; cyc <= 160; cyc++) begin
      step();
      e_dot  = cyc % 16;
      e_ly   = (cyc / 16) % 5;
      e_mode = exp_mode(e_ly, e_dot, 3, 4, 10);
      chk("c_dot", 32'(dot_c), e_dot);
      chk("c_ly", 32'(ly_c), e_ly);
      chk("c_mode", 32'(mode_c), e_mode);
      chk("c_oam_lock", 32'(ol_c), (e_mode >= 2) ? 1 : 0);
      chk("c_vram_lock", 32'(vl_c), (e_mode == 3) ? 1 : 0);
      chk("c_drawline", 32'(dl_c), (e_ly < 3 && e_dot == 4) ? 1 : 0);
      chk("c_vblank_irq", 32'(vb_c), (e_ly == 3 && e_dot == 0) ? 1 : 0);
      chk("c_frame_done", 32'(fd_c), (e_ly == 4 && e_dot == 15) ? 1 : 0);
      chk("c_lyc_match", 32'(lm_c), (e_ly == lyc_cur) ? 1 : 0);
      chk("c_stat_irq_oam", 32'(st_c), (e_ly < 3 && e_dot == 0) ? 1 : 0);
      if (e_ly == 2 && e_dot == 5 && cyc < 80) begin
        lyc_c = 8'd3; lyc_cur = 3;
        step();
        chk("c_lyc_drop_next_edge", 32'(lm_c), 0);
        chk("c_lyc_drop_dot", 32'(dot_c), 6);
        cyc++;
      end
    end

    // Asynchronous reset in the middle of a line clears without a clock edge.
    repeat (7) step();
    chk("c_pre_reset_dot", 32'(dot_c), 7);
    #1 rst_c = 1'b0;
    #1;
    chk("c_async_reset_all_zero", 32'(all_c), 0);
    rst_c = 1'b1;
    step();
    chk("c_after_reset_dot", 32'(dot_c), 0);
    chk("c_after_reset_ly", 32'(ly_c), 0);
    chk("c_after_reset_mode", 32'(mode_c), 2);
    chk("c_after_reset_no_irq", 32'(st_c), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
